// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one request at a time, fixed latency, one-cycle ack.
// Optional address-range checking is enabled with `define DMEM_RANGE_CHECK_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wen,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                rearm;
    logic                hold_wen;
    logic [DATA_W-1:0]   hold_addr, hold_wdata;
    logic                accept_c, access_c, acc_wen_c, acc_oor_c;
    logic [DATA_W-1:0]   acc_addr_c, acc_wdata_c;
    logic [ADDR_W-1:0]   acc_idx_c;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Next state and access control; with LATENCY==1 the access happens on the accept edge from live inputs.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        accept_c    = 1'b0;
        access_c    = 1'b0;
        acc_wen_c   = hold_wen;
        acc_addr_c  = hold_addr;
        acc_wdata_c = hold_wdata;
        case (state)
            S_IDLE: begin
                // rearm enforces one idle cycle after every response before the next accept
                if (req && !rearm) begin
                    accept_c = 1'b1;
                    cnt_nxt  = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt   = S_RESP;
                        access_c    = 1'b1;
                        acc_wen_c   = wen;
                        acc_addr_c  = addr;
                        acc_wdata_c = wdata;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_RESP;
                    access_c  = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign acc_idx_c = acc_addr_c[ADDR_W-1:0];
    assign acc_oor_c = RANGE_EN && (acc_addr_c[DATA_W-1:ADDR_W] != '0);
    assign busy      = (state == S_IDLE && req) || (state == S_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rearm      <= 1'b0;
            hold_wen   <= 1'b1;
            hold_addr  <= '0;
            hold_wdata <= '0;
            rdata      <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rearm <= (state == S_RESP);
            ack   <= access_c;
            err   <= access_c && acc_oor_c;
            if (accept_c) begin
                hold_wen   <= wen;
                hold_addr  <= addr;
                hold_wdata <= wdata;
            end
            if (access_c && (acc_oor_c || acc_wen_c)) begin
                rdata <= acc_oor_c ? '0 : mem[acc_idx_c];
            end
        end
    end

    // RAM is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && access_c && !acc_wen_c && !acc_oor_c) begin
            mem[acc_idx_c] <= acc_wdata_c;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for single transactions and a LATENCY=1 instance for back-to-back.
module tb_dmem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LAT    = 2;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk, rst;
    logic        req, wen, ack, busy, err;
    logic [15:0] addr, wdata, rdata;
    logic        req1, wen1, ack1, busy1, err1;
    logic [15:0] addr1, wdata1, rdata1;

    exp_t        sb[$];
    exp_t        sb1[$];
    logic [15:0] ref_mem [256];
    logic [15:0] last_rd;
    int          errors = 0;
    int          checks = 0;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .err(err)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .wen(wen1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for the LATENCY=2 instance; returns what the ack cycle must show.
    function automatic exp_t predict(input logic [15:0] a, input logic w, input logic [15:0] d);
        exp_t e;
        if (RCHK && a[15:8] != 8'h00) begin
            last_rd = 16'h0000;
            e.rdata = 16'h0000;
            e.err   = 1'b1;
        end else begin
            if (!w) ref_mem[a[7:0]] = d;
            else    last_rd = ref_mem[a[7:0]];
            e.rdata = last_rd;
            e.err   = 1'b0;
        end
        return e;
    endfunction

    task automatic txn(input logic [15:0] a, input logic w, input logic [15:0] d, input bit garble);
        exp_t e;
        int   n;
        bit   got;
        @(posedge clk); #1;
        req = 1'b1; wen = w; addr = a; wdata = d;
        sb.push_back(predict(a, w, d));
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL txn_busy_accept addr=%h got=%b want=1", a, busy); end
        got = 1'b0;
        n   = 0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            req = 1'b0;
            if (garble) begin addr = ~a; wdata = ~d; wen = ~w; end
            #1;
            if (ack === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                checks++;
                if (rdata !== e.rdata) begin errors++; $display("FAIL txn_rdata addr=%h got=%h want=%h", a, rdata, e.rdata); end
                checks++;
                if (err !== e.err) begin errors++; $display("FAIL txn_err addr=%h got=%b want=%b", a, err, e.err); end
                checks++;
                if (n != LAT) begin errors++; $display("FAIL txn_latency addr=%h got=%0d want=%0d", a, n, LAT); end
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL txn_busy_resp addr=%h got=%b want=0", a, busy); end
            end else begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL txn_busy_wait addr=%h got=%b want=1", a, busy); end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout addr=%h no ack within %0d cycles want ack", a, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk); #1;
        addr = 16'h0000; wdata = 16'h0000; wen = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL txn_ack_width addr=%h got=%b want=0", a, ack); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", ack); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (rdata1 !== 16'h0000 || ack1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL reset_dut1 got=%h/%b/%b want=0000/0/0", rdata1, ack1, busy1);
        end
        req = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_follows_req got=%b want=1", busy); end
        req = 1'b0;
        rst = 1'b1;
        last_rd = 16'h0000;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got=%b want=0", busy); end
    endtask

    task automatic test_store_load();
        txn(16'h0005, 1'b0, 16'hBEEF, 1'b0);
        txn(16'h0005, 1'b1, 16'h0000, 1'b0);
        txn(16'h0009, 1'b0, 16'hCAFE, 1'b0);
        txn(16'h0009, 1'b1, 16'h0000, 1'b0);
        txn(16'h0005, 1'b1, 16'h0000, 1'b0);
    endtask

    task automatic test_input_hold();
        txn(16'h0020, 1'b0, 16'h1357, 1'b1);
        txn(16'h0020, 1'b1, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        txn(16'h0007, 1'b0, 16'h5A5A, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; wen = 1'b0; addr = 16'h0007; wdata = 16'h1234;
        @(posedge clk); #1;
        req = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy got=%b want=1", busy); end
        rst = 1'b0;
        last_rd = 16'h0000;
        #1;
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0 || rdata !== 16'h0000) begin
            errors++; $display("FAIL midwait_reset got=%b/%b/%h want=0/0/0000", busy, ack, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        wen = 1'b1; addr = 16'h0000; wdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            checks++;
            if (ack !== 1'b0) begin errors++; $display("FAIL midwait_no_ack cycle=%0d got=%b want=0", i, ack); end
        end
        txn(16'h0007, 1'b1, 16'h0000, 1'b0);
    endtask

    task automatic test_range();
        txn(16'h0005, 1'b0, 16'h1111, 1'b0);
        txn(16'h0105, 1'b0, 16'hA5A5, 1'b0);
        txn(16'h0005, 1'b1, 16'h0000, 1'b0);
        txn(16'h0105, 1'b1, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit   bexp [6];
        bit   aexp [6];
        exp_t e;
        bexp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        aexp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        @(posedge clk); #1;
        req1 = 1'b1; wen1 = 1'b0; addr1 = 16'h0001; wdata1 = 16'h0F0F;
        @(posedge clk); #1;
        req1 = 1'b0; wen1 = 1'b1; wdata1 = 16'h0000;
        #1;
        checks++;
        if (ack1 !== 1'b1) begin errors++; $display("FAIL b2b_store_ack got=%b want=1", ack1); end
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        req1 = 1'b1; wen1 = 1'b1; addr1 = 16'h0001;
        e.rdata = 16'h0F0F;
        e.err   = 1'b0;
        sb1.push_back(e);
        sb1.push_back(e);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            #1;
            checks++;
            if (busy1 !== bexp[i]) begin errors++; $display("FAIL b2b_busy cycle=%0d got=%b want=%b", i, busy1, bexp[i]); end
            checks++;
            if (ack1 !== aexp[i]) begin errors++; $display("FAIL b2b_ack cycle=%0d got=%b want=%b", i, ack1, aexp[i]); end
            if (ack1 === 1'b1 && sb1.size() > 0) begin
                e = sb1.pop_front();
                checks++;
                if (rdata1 !== e.rdata || err1 !== e.err) begin
                    errors++; $display("FAIL b2b_rdata cycle=%0d got=%h/%b want=%h/%b", i, rdata1, err1, e.rdata, e.err);
                end
            end
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        checks++;
        if (sb1.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d want=0", sb1.size()); end
    endtask

    initial begin
        rst = 1'b0;
        req = 1'b0; wen = 1'b1; addr = 16'h0000; wdata = 16'h0000;
        req1 = 1'b0; wen1 = 1'b1; addr1 = 16'h0000; wdata1 = 16'h0000;
        last_rd = 16'h0000;
        test_reset();
        test_store_load();
        test_input_hold();
        test_reset_mid_wait();
        test_range();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish want finish");
        $fatal(1);
    end

endmodule
